// File: rtl/fpu_addsub_param.sv
// Sequential IEEE-754 add/subtract unit, one operation in flight, req/ack on both sides.
// Format width set by EXP_W/MANT_W; four rounding modes and {invalid, overflow, underflow, inexact} flags.
//
// state  | meaning
// IDLE   | in_ack high, waiting for operands
// UNPACK | split fields, resolve NaN/inf/zero directly to OUTPUT
// ALIGN  | shift smaller-exponent mantissa right with sticky
// ADD    | add or subtract magnitudes, absorb carry-out
// NORM_1 | shift left until hidden bit set or exponent reaches emin
// NORM_2 | shift right while exponent is below emin
// ROUND  | round, detect overflow/underflow, pack result
// OUTPUT | hold result until out_z_ack
module fpu_addsub_param #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [EXP_W+MANT_W:0]         in_a,
  input  logic [EXP_W+MANT_W:0]         in_b,
  input  logic                          in_op,
  input  logic [1:0]                    in_rm,
  input  logic                          in_req,
  output logic                          in_ack,
  output logic [EXP_W+MANT_W:0]         out_z,
  output logic [3:0]                    out_flags,
  output logic                          out_z_req,
  input  logic                          out_z_ack
);
  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int MW   = MANT_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_E    = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN      = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] SHIFT_MAX = EW'(MANT_W + 3);
  localparam logic signed [EW-1:0] ONE_E     = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM_1, NORM_2, ROUND, OUTPUT} state_t;
  state_t state;

  logic [W-1:0]          a_r, b_r;
  logic                  op_r;
  logic [1:0]            rm_r;
  logic                  a_s, b_s, z_s;
  logic signed [EW-1:0]  a_e, b_e, z_e;
  logic [MW-1:0]         a_m, b_m, z_m;

  // operand decode straight from the captured words
  logic [EXP_W-1:0]  a_ef, b_ef;
  logic [MANT_W-1:0] a_f, b_f;
  logic a_sg, b_sg, a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
  logic spec_hit, spec_inv;
  logic [W-1:0] spec_z;

  always_comb begin
    a_ef   = a_r[W-2:MANT_W];
    b_ef   = b_r[W-2:MANT_W];
    a_f    = a_r[MANT_W-1:0];
    b_f    = b_r[MANT_W-1:0];
    a_sg   = a_r[W-1];
    b_sg   = b_r[W-1] ^ op_r;
    a_inf  = (&a_ef) && (a_f == '0);
    b_inf  = (&b_ef) && (b_f == '0);
    a_nan  = (&a_ef) && (a_f != '0);
    b_nan  = (&b_ef) && (b_f != '0);
    a_zero = (a_ef == '0) && (a_f == '0);
    b_zero = (b_ef == '0) && (b_f == '0);
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_z   = '0;
    if (a_nan || b_nan) begin
      spec_z   = QNAN;
      spec_inv = (a_nan && !a_f[MANT_W-1]) || (b_nan && !b_f[MANT_W-1]);
    end else if (a_inf && b_inf && (a_sg != b_sg)) begin
      spec_z   = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_z = a_r;
    end else if (b_inf || a_zero) begin
      spec_z = {b_sg, b_r[W-2:0]};
      if (b_zero)
        spec_z[W-1] = (a_sg & b_sg) | ((a_sg ^ b_sg) & (rm_r == 2'd3));
    end else if (b_zero) begin
      spec_z = a_r;
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic signed [EW-1:0] diff_ab, diff_ba;
  logic [MW:0]          sum;
  logic                 sum_s;

  always_comb begin
    diff_ab = a_e - b_e;
    diff_ba = b_e - a_e;
    sum     = '0;
    sum_s   = a_s;
    if (a_s == b_s)
      sum = {1'b0, a_m} + {1'b0, b_m};
    else if (a_m >= b_m)
      sum = {1'b0, a_m} - {1'b0, b_m};
    else begin
      sum   = {1'b0, b_m} - {1'b0, a_m};
      sum_s = b_s;
    end
  end

  logic                 g, r, s, inc, ovf, inx, to_inf;
  logic [MANT_W+1:0]    rnd_sum;
  logic [MANT_W:0]      rnd_mf;
  logic signed [EW-1:0] rnd_e;
  logic [EXP_W-1:0]     rnd_exp;
  logic [W-1:0]         rnd_z;

  always_comb begin
    g = z_m[2];
    r = z_m[1];
    s = z_m[0];
    case (rm_r)
      2'd0:    inc = g & (r | s | z_m[3]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = (g | r | s) & ~z_s;
      default: inc = (g | r | s) & z_s;
    endcase
    rnd_sum = {1'b0, z_m[MW-1:3]} + {{(MANT_W+1){1'b0}}, inc};
    if (rnd_sum[MANT_W+1]) begin
      rnd_mf = rnd_sum[MANT_W+1:1];
      rnd_e  = z_e + ONE_E;
    end else begin
      rnd_mf = rnd_sum[MANT_W:0];
      rnd_e  = z_e;
    end
    ovf     = rnd_e > BIAS_E;
    inx     = g | r | s | ovf;
    rnd_exp = rnd_mf[MANT_W] ? EXP_W'(rnd_e + BIAS_E) : '0;
    to_inf  = (rm_r == 2'd0) || (rm_r == 2'd2 && !z_s) || (rm_r == 2'd3 && z_s);
    if (!ovf)
      rnd_z = {z_s, rnd_exp, rnd_mf[MANT_W-1:0]};
    else if (to_inf)
      rnd_z = {z_s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else
      rnd_z = {z_s, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ack    <= 1'b0;
      out_z_req <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ack && in_req) begin
            a_r    <= in_a;
            b_r    <= in_b;
            op_r   <= in_op;
            rm_r   <= in_rm;
            in_ack <= 1'b0;
            state  <= UNPACK;
          end else begin
            in_ack <= 1'b1;
          end
        end
        UNPACK: begin
          a_s <= a_sg;
          b_s <= b_sg;
          a_e <= (a_ef == '0) ? EMIN : $signed({2'b00, a_ef}) - BIAS_E;
          b_e <= (b_ef == '0) ? EMIN : $signed({2'b00, b_ef}) - BIAS_E;
          a_m <= {|a_ef, a_f, 3'b000};
          b_m <= {|b_ef, b_f, 3'b000};
          if (spec_hit) begin
            out_z     <= spec_z;
            out_flags <= {spec_inv, 3'b000};
            out_z_req <= 1'b1;
            state     <= OUTPUT;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (diff_ab > SHIFT_MAX) begin
            b_m <= {{(MW-1){1'b0}}, |b_m};
            b_e <= a_e;
          end else if (diff_ab > 0) begin
            b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
            b_e <= b_e + ONE_E;
          end else if (diff_ba > SHIFT_MAX) begin
            a_m <= {{(MW-1){1'b0}}, |a_m};
            a_e <= b_e;
          end else if (diff_ba > 0) begin
            a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
            a_e <= a_e + ONE_E;
          end else begin
            state <= ADD;
          end
        end
        ADD: begin
          // exact cancellation: +0 unless rounding toward -inf
          z_s <= (sum == '0) ? (rm_r == 2'd3) : sum_s;
          if (sum[MW]) begin
            z_m <= {sum[MW:2], sum[1] | sum[0]};
            z_e <= a_e + ONE_E;
          end else begin
            z_m <= sum[MW-1:0];
            z_e <= a_e;
          end
          state <= NORM_1;
        end
        NORM_1: begin
          if (!z_m[MW-1] && (z_e > EMIN)) begin
            z_m <= {z_m[MW-2:0], 1'b0};
            z_e <= z_e - ONE_E;
          end else begin
            state <= NORM_2;
          end
        end
        NORM_2: begin
          if (z_e < EMIN) begin
            z_m <= {1'b0, z_m[MW-1:2], z_m[1] | z_m[0]};
            z_e <= z_e + ONE_E;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_z     <= rnd_z;
          out_flags <= {1'b0, ovf, inx & !rnd_mf[MANT_W], inx};
          out_z_req <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_z_ack) begin
            out_z_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
